// File: rtl/ace_vram_arbiter_pkg.sv
// Shared constants and state encoding for the Jupiter Ace video/character RAM arbiter.
package ace_mem_pkg;

    localparam logic [3:0] ACE_VRAM_PAGE    = 4'h2;
    localparam int         ACE_CHARSET_BIT  = 11;
    localparam int         ACE_NOWAIT_BIT   = 10;
    localparam logic [7:0] ACE_CPU_DI_RESET = 8'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RDATA = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        VRAM_IDLE  = ST_IDLE,
        VRAM_RDATA = ST_RDATA,
        VRAM_DONE  = ST_DONE
    } vram_state_e;

endpackage

// File: rtl/ace_vram_arbiter_if.sv
// CPU bus, video fetch and RAM port bundle seen by the VRAM arbiter.
interface ace_vram_if #(
    parameter int RAM_AW = 11
);
    logic [15:0]       cpu_a;
    logic              cpu_mreq_n;
    logic              cpu_rd_n;
    logic              cpu_wr_n;
    logic [7:0]        cpu_do;
    logic [7:0]        cpu_di;
    logic              cpu_sel;
    logic              cpu_wait_n;
    logic              vid_active;
    logic              vid_req;
    logic [RAM_AW-1:0] vid_addr;
    logic              vid_ack;
    logic              vid_valid;
    logic [7:0]        vid_data;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    modport slave (
        input  cpu_a, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_do,
        output cpu_di, cpu_sel, cpu_wait_n,
        input  vid_active, vid_req, vid_addr,
        output vid_ack, vid_valid, vid_data,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_a, cpu_mreq_n, cpu_rd_n, cpu_wr_n, cpu_do,
        input  cpu_di, cpu_sel, cpu_wait_n,
        output vid_active, vid_req, vid_addr,
        input  vid_ack, vid_valid, vid_data,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ace_vram_arbiter_decode.sv
// Combinational decode of CPU memory cycles in the 0x2000-0x2FFF VRAM page.
module ace_vram_decode
    import ace_mem_pkg::*;
#(
    parameter int RAM_AW = 11
) (
    input  logic [15:0]       cpu_a,
    input  logic              cpu_mreq_n,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    output logic              hit,
    output logic              contended,
    output logic [RAM_AW-1:0] ram_addr
);

    assign hit       = (cpu_a[15:12] == ACE_VRAM_PAGE) && !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    assign contended = !cpu_a[ACE_NOWAIT_BIT];

    // Bit 10 only selects the no-wait mirror, so it is dropped from the RAM address.
    assign ram_addr  = RAM_AW'({cpu_a[ACE_CHARSET_BIT], cpu_a[9:0]});

endmodule

// File: rtl/ace_vram_arbiter.sv
// Single-port VRAM arbiter: video fetches have strict priority, CPU cycles are
// stretched with cpu_wait_n until their one RAM access has completed.
module ace_vram_arbiter
    import ace_mem_pkg::*;
#(
    parameter int RAM_AW = 11
) (
    input  logic        clk,
    input  logic        reset,
    ace_vram_if.slave   bus
);

    logic              hit;
    logic              contended;
    logic [RAM_AW-1:0] cpu_ram_addr;
    logic              blocked;
    logic              cpu_go;
    logic              vid_grant;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        cpu_di_q;
    logic              ack_q;
    logic [7:0]        vid_data_q;

    ace_vram_decode #(
        .RAM_AW (RAM_AW)
    ) u_decode (
        .cpu_a      (bus.cpu_a),
        .cpu_mreq_n (bus.cpu_mreq_n),
        .cpu_rd_n   (bus.cpu_rd_n),
        .cpu_wr_n   (bus.cpu_wr_n),
        .hit        (hit),
        .contended  (contended),
        .ram_addr   (cpu_ram_addr)
    );

    assign blocked   = hit && contended && bus.vid_active;

    // Grants are gated by reset so an abandoned access can never leak a write.
    assign vid_grant = (state != ST_RDATA) && bus.vid_req && !reset;
    assign cpu_go    = (state == ST_IDLE) && !bus.vid_req && hit && !blocked && !reset;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!bus.vid_req && hit && !blocked)
                    state_nxt = !bus.cpu_wr_n ? ST_DONE : ST_RDATA;
            end
            ST_RDATA: state_nxt = ST_DONE;
            ST_DONE: begin
                if (bus.cpu_mreq_n)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cpu_di_q   <= ACE_CPU_DI_RESET;
            ack_q      <= 1'b0;
            vid_data_q <= 8'h00;
        end else begin
            state <= state_nxt;
            ack_q <= vid_grant;
            if (state == ST_RDATA)
                cpu_di_q <= bus.ram_rdata;
            if (ack_q)
                vid_data_q <= bus.ram_rdata;
        end
    end

    assign bus.cpu_sel    = hit;
    assign bus.cpu_wait_n = reset || !(hit && (state != ST_DONE));
    assign bus.cpu_di     = cpu_di_q;

    assign bus.ram_addr   = vid_grant ? bus.vid_addr : cpu_ram_addr;
    assign bus.ram_we     = cpu_go && !bus.cpu_wr_n;
    assign bus.ram_wdata  = bus.cpu_do;

    // The fetched byte is forwarded during the valid pulse and held afterwards.
    assign bus.vid_ack    = vid_grant;
    assign bus.vid_valid  = ack_q;
    assign bus.vid_data   = ack_q ? bus.ram_rdata : vid_data_q;

endmodule

// File: tb/tb_ace_vram_arbiter.sv
// Directed bench for ace_vram_arbiter with a behavioural synchronous 2 KB RAM.
module tb_ace_vram_arbiter;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ace_vram_if #(.RAM_AW(11)) bus ();

    ace_vram_arbiter #(.RAM_AW(11)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  mem [0:2047];
    logic        pl_we;
    logic [10:0] pl_addr;
    logic [7:0]  pl_data;

    always @(posedge clk) begin
        if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
        else if (pl_we)
            mem[pl_addr] <= pl_data;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic mreq_n, input logic rd_n,
                                 input logic wr_n, input logic [7:0] dout);
        bus.cpu_a      = a;
        bus.cpu_mreq_n = mreq_n;
        bus.cpu_rd_n   = rd_n;
        bus.cpu_wr_n   = wr_n;
        bus.cpu_do     = dout;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleBus();
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic preload(input logic [10:0] addr, input logic [7:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_we   = 1'b1;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_cpu_di"},    32'(bus.cpu_di),     32'h0000_00FF);
        checkOutput({tag, "_wait_n"},    32'(bus.cpu_wait_n), 32'd1);
        checkOutput({tag, "_ram_we"},    32'(bus.ram_we),     32'd0);
        checkOutput({tag, "_vid_ack"},   32'(bus.vid_ack),    32'd0);
        checkOutput({tag, "_vid_valid"}, 32'(bus.vid_valid),  32'd0);
        checkOutput({tag, "_vid_data"},  32'(bus.vid_data),   32'd0);
    endtask

    int low_cnt;
    int we_cnt;

    initial begin
        reset          = 1'b1;
        pl_we          = 1'b0;
        pl_addr        = '0;
        pl_data        = '0;
        bus.vid_active = 1'b0;
        bus.vid_req    = 1'b0;
        bus.vid_addr   = '0;
        idleBus();
        @(negedge clk);
        preload(11'h403, 8'hC3);
        preload(11'h010, 8'h77);
        preload(11'h012, 8'h34);
        preload(11'h405, 8'h9E);
        #1;
        checkResetOutputs("rst_init");
        reset = 1'b0;
        tick();

        // Uncontended-mirror write: one ram_we cycle, wait for one clk.
        applyStimulus(16'h2400, 1'b0, 1'b1, 1'b0, 8'h5A);
        #1;
        checkOutput("wr_ram_we",    32'(bus.ram_we),     32'd1);
        checkOutput("wr_ram_addr",  32'(bus.ram_addr),   32'h000);
        checkOutput("wr_ram_wdata", 32'(bus.ram_wdata),  32'h5A);
        checkOutput("wr_wait_low",  32'(bus.cpu_wait_n), 32'd0);
        checkOutput("wr_cpu_sel",   32'(bus.cpu_sel),    32'd1);
        tick();
        #1;
        checkOutput("wr_wait_high", 32'(bus.cpu_wait_n), 32'd1);
        checkOutput("wr_we_once",   32'(bus.ram_we),     32'd0);
        idleBus();
        tick();
        checkOutput("wr_mem",       32'(mem[11'h000]),   32'h5A);

        // Charset read through the mirror: wait low for exactly two clks.
        applyStimulus(16'h2C03, 1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        checkOutput("rd_wait_c0", 32'(bus.cpu_wait_n), 32'd0);
        tick();
        #1;
        checkOutput("rd_wait_c1", 32'(bus.cpu_wait_n), 32'd0);
        tick();
        #1;
        checkOutput("rd_wait_c2", 32'(bus.cpu_wait_n), 32'd1);
        checkOutput("rd_cpu_di",  32'(bus.cpu_di),     32'hC3);
        idleBus();
        tick();

        // Contended read during the active display is held off entirely.
        bus.vid_active = 1'b1;
        applyStimulus(16'h2010, 1'b0, 1'b0, 1'b1, 8'h00);
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.cpu_wait_n == 1'b0)
                low_cnt++;
            tick();
        end
        checkOutput("blk_wait_low", 32'(low_cnt),   32'd20);
        checkOutput("blk_di_held",  32'(bus.cpu_di), 32'hC3);
        bus.vid_active = 1'b0;
        #1;
        checkOutput("blk_rel_c0", 32'(bus.cpu_wait_n), 32'd0);
        tick();
        #1;
        checkOutput("blk_rel_c1", 32'(bus.cpu_wait_n), 32'd0);
        tick();
        #1;
        checkOutput("blk_rel_c2", 32'(bus.cpu_wait_n), 32'd1);
        checkOutput("blk_cpu_di", 32'(bus.cpu_di),     32'h77);
        idleBus();
        tick();

        // Video request and CPU read in the same clk: video wins.
        bus.vid_req  = 1'b1;
        bus.vid_addr = 11'h405;
        applyStimulus(16'h2412, 1'b0, 1'b0, 1'b1, 8'h00);
        #1;
        checkOutput("pri_vid_ack",  32'(bus.vid_ack),    32'd1);
        checkOutput("pri_vid_addr", 32'(bus.ram_addr),   32'h405);
        checkOutput("pri_wait_c0",  32'(bus.cpu_wait_n), 32'd0);
        tick();
        bus.vid_req = 1'b0;
        #1;
        checkOutput("pri_ack_done",  32'(bus.vid_ack),   32'd0);
        checkOutput("pri_vid_valid", 32'(bus.vid_valid), 32'd1);
        checkOutput("pri_vid_data",  32'(bus.vid_data),  32'h9E);
        checkOutput("pri_cpu_addr",  32'(bus.ram_addr),  32'h012);
        tick();
        #1;
        checkOutput("pri_valid_pulse", 32'(bus.vid_valid),  32'd0);
        checkOutput("pri_data_held",   32'(bus.vid_data),   32'h9E);
        checkOutput("pri_wait_c2",     32'(bus.cpu_wait_n), 32'd0);
        tick();
        #1;
        checkOutput("pri_wait_c3", 32'(bus.cpu_wait_n), 32'd1);
        checkOutput("pri_cpu_di",  32'(bus.cpu_di),     32'h34);
        idleBus();
        tick();

        // Reset in the middle of a read; a pending write must never issue.
        applyStimulus(16'h2C03, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        #1;
        checkOutput("mid_rdata_wait", 32'(bus.cpu_wait_n), 32'd0);
        #1;
        reset       = 1'b1;
        bus.vid_req = 1'b1;
        applyStimulus(16'h2400, 1'b0, 1'b1, 1'b0, 8'hAA);
        #1;
        checkResetOutputs("rst_mid");
        tick();
        #1;
        checkResetOutputs("rst_hold");
        reset       = 1'b0;
        bus.vid_req = 1'b0;
        idleBus();
        tick();
        checkOutput("rst_no_write", 32'(mem[11'h000]), 32'h5A);
        applyStimulus(16'h2C03, 1'b0, 1'b0, 1'b1, 8'h00);
        tick();
        tick();
        #1;
        checkOutput("rst_resume_wait", 32'(bus.cpu_wait_n), 32'd1);
        checkOutput("rst_resume_di",   32'(bus.cpu_di),     32'hC3);
        idleBus();
        tick();

        // Long mreq_n on a charset write: one access, DONE held until release.
        applyStimulus(16'h2800, 1'b0, 1'b1, 1'b0, 8'h11);
        we_cnt  = 0;
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.ram_we)
                we_cnt++;
            if (bus.cpu_wait_n == 1'b0)
                low_cnt++;
            tick();
        end
        checkOutput("long_we_count", 32'(we_cnt),  32'd1);
        checkOutput("long_wait_low", 32'(low_cnt), 32'd1);
        idleBus();
        tick();
        checkOutput("long_mem", 32'(mem[11'h400]), 32'h11);
        applyStimulus(16'h2800, 1'b0, 1'b1, 1'b0, 8'h22);
        #1;
        checkOutput("long_back_idle", 32'(bus.ram_we), 32'd1);
        tick();
        idleBus();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
